// File: rtl/bluetooth_byte_rx_if.sv
// Serial receive bundle: line and rate select in, received byte and status pulses out.
interface bluetooth_byte_rx_if;
  logic       uart_rx;
  logic [2:0] baud_set;
  logic [7:0] data_byte;
  logic       rx_done;
  logic       frame_err;
  logic       uart_state;

  modport master (output uart_rx, baud_set, input data_byte, rx_done, frame_err, uart_state);
  modport slave  (input uart_rx, baud_set, output data_byte, rx_done, frame_err, uart_state);
endinterface

// File: rtl/bluetooth_byte_rx.sv
// 8N1 UART byte receiver with selectable baud rate.
// Define BT_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit target.
module bluetooth_byte_rx (
  input  logic                clk,
  input  logic                reset,
  bluetooth_byte_rx_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      r_state;
  logic        r_sync1, r_sync2, r_sync3;
  logic [12:0] r_div;
  logic [12:0] r_bps;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_done, r_ferr, r_busy;

  logic        w_fall;
  logic [12:0] w_half;
  logic        w_start_hit;
  logic        w_bit_hit;
  logic        w_smp;

  function automatic logic [12:0] bps_of(input logic [2:0] bs);
    case (bs)
      3'd1:    return 13'd2603;
      3'd2:    return 13'd1301;
      3'd3:    return 13'd867;
      3'd4:    return 13'd433;
      default: return 13'd5207;
    endcase
  endfunction

  assign w_fall = r_sync3 & ~r_sync2;
  assign w_half = {1'b0, r_bps[12:1]};

`ifdef BT_RX_MAJORITY_EN
  // Two prior samples; the decision clock supplies the third (target+1).
  logic [1:0] r_hist;

  always_ff @(posedge clk) begin
    if (reset) r_hist <= 2'b11;
    else       r_hist <= {r_hist[0], r_sync2};
  end

  assign w_start_hit = (r_div == w_half + 13'd1);
  assign w_bit_hit   = (r_div == r_bps + 13'd1);
  assign w_smp       = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_sync2) | (r_hist[0] & r_sync2);
`else
  assign w_start_hit = (r_div == w_half);
  assign w_bit_hit   = (r_div == r_bps);
  assign w_smp       = r_sync2;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
      r_div   <= '0;
      r_bps   <= 13'd5207;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_sync1 <= bus.uart_rx;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_div <= '0;
          if (w_fall) begin
            r_state <= S_START;
            r_bps   <= bps_of(bus.baud_set);
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (w_start_hit) begin
            r_div <= '0;
            r_bit <= '0;
            if (!w_smp) begin
              r_state <= S_DATA;
            end else begin
              // Glitch shorter than half a bit: drop it silently.
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_div <= r_div + 13'd1;
          end
        end
        S_DATA: begin
          if (w_bit_hit) begin
            r_div   <= '0;
            r_shift <= {w_smp, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= S_STOP;
          end else begin
            r_div <= r_div + 13'd1;
          end
        end
        S_STOP: begin
          if (w_bit_hit) begin
            // Leaving at mid stop bit leaves room to catch a back-to-back start edge.
            if (w_smp) begin
              r_data <= r_shift;
              r_done <= 1'b1;
            end else begin
              r_ferr <= 1'b1;
            end
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_div   <= '0;
          end else begin
            r_div <= r_div + 13'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_div   <= '0;
        end
      endcase
    end
  end

  assign bus.data_byte  = r_data;
  assign bus.rx_done    = r_done;
  assign bus.frame_err  = r_ferr;
  assign bus.uart_state = r_busy;
endmodule

// File: tb/tb_bluetooth_byte_rx.sv
// Directed bench for bluetooth_byte_rx: framing, rates, false starts, errors, reset, glitch.
module tb_bluetooth_byte_rx;
  localparam int BIT4 = 434;

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_done  = 0;
  int   n_err   = 0;
  int   n_both  = 0;
  int   n_long  = 0;
  logic p_done  = 1'b0;
  logic p_err   = 1'b0;

  bluetooth_byte_rx_if bus ();

  bluetooth_byte_rx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(negedge clk) begin
    if (bus.rx_done) n_done++;
    if (bus.frame_err) n_err++;
    if (bus.rx_done && bus.frame_err) n_both++;
    if ((bus.rx_done && p_done) || (bus.frame_err && p_err)) n_long++;
    p_done = bus.rx_done;
    p_err  = bus.frame_err;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Drives a 10-bit frame clock by clock from index from_c; stops before index abort_at.
  task automatic frame(input logic [7:0] b, input logic stop_v, input int from_c,
                       input int abort_at, input int glitch_at);
    logic [9:0] f;
    f = {stop_v, b, 1'b0};
    for (int c = from_c; c < 10 * BIT4; c++) begin
      if (c == abort_at) break;
      @(negedge clk);
      bus.uart_rx = f[c / BIT4] ^ (c == glitch_at);
    end
  endtask

  task automatic false_start(input logic [2:0] bs, input int h, input string tag);
    bus.baud_set = bs;
    @(negedge clk);
    bus.uart_rx = 1'b0;
    for (int k = 1; k <= h + 6; k++) begin
      @(negedge clk);
      if (k == 100) bus.uart_rx = 1'b1;
      if (k == 3)     chk({tag, "_enter"}, 16'(bus.uart_state), 16'd1);
      if (k == h)     chk({tag, "_busy"},  16'(bus.uart_state), 16'd1);
      if (k == h + 6) chk({tag, "_idle"},  16'(bus.uart_state), 16'd0);
    end
    bus.baud_set = 3'd4;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    reset        = 1'b1;
    bus.uart_rx  = 1'b1;
    bus.baud_set = 3'd4;
    repeat (3) @(negedge clk);
    chk("rst_data",  16'(bus.data_byte),  16'h00);
    chk("rst_done",  16'(bus.rx_done),    16'd0);
    chk("rst_ferr",  16'(bus.frame_err),  16'd0);
    chk("rst_state", 16'(bus.uart_state), 16'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // 0x55 at 115200
    frame(8'h55, 1'b1, 0, 2000, -1);
    chk("f55_busy", 16'(bus.uart_state), 16'd1);
    frame(8'h55, 1'b1, 2000, -1, -1);
    repeat (5) @(negedge clk);
    chk("f55_ndone", 16'(n_done), 16'd1);
    chk("f55_data",  16'(bus.data_byte), 16'h55);
    chk("f55_nerr",  16'(n_err), 16'd0);
    chk("f55_idle",  16'(bus.uart_state), 16'd0);

    // bad stop bit, then line held low must not retrigger
    frame(8'hA5, 1'b0, 0, -1, -1);
    chk("fe_nerr",  16'(n_err), 16'd1);
    chk("fe_ndone", 16'(n_done), 16'd1);
    chk("fe_data",  16'(bus.data_byte), 16'h55);
    repeat (1000) @(negedge clk);
    chk("fe_lowidle", 16'(bus.uart_state), 16'd0);
    chk("fe_nerr2",   16'(n_err), 16'd1);
    bus.uart_rx = 1'b1;
    repeat (20) @(negedge clk);

    // back-to-back frames
    frame(8'h00, 1'b1, 0, -1, -1);
    chk("b2b0_data",  16'(bus.data_byte), 16'h00);
    chk("b2b0_ndone", 16'(n_done), 16'd2);
    frame(8'hFF, 1'b1, 0, -1, -1);
    chk("b2b1_data",  16'(bus.data_byte), 16'hFF);
    chk("b2b1_ndone", 16'(n_done), 16'd3);
    repeat (20) @(negedge clk);

    // rate select change mid-frame is ignored
    frame(8'hA3, 1'b1, 0, 600, -1);
    bus.baud_set = 3'd0;
    frame(8'hA3, 1'b1, 600, -1, -1);
    bus.baud_set = 3'd4;
    repeat (20) @(negedge clk);
    chk("bchg_data",  16'(bus.data_byte), 16'hA3);
    chk("bchg_ndone", 16'(n_done), 16'd4);

    // false starts: half-bit timing per rate
    false_start(3'd4, 216,  "fs4");
    false_start(3'd3, 433,  "fs3");
    false_start(3'd2, 650,  "fs2");
    false_start(3'd1, 1301, "fs1");
    false_start(3'd0, 2603, "fs0");
    false_start(3'd7, 2603, "fs7");
    chk("fs_ndone", 16'(n_done), 16'd4);
    chk("fs_nerr",  16'(n_err),  16'd1);

    // reset at mid bit 3 of 0x3C
    frame(8'h3C, 1'b1, 0, 1953, -1);
    chk("rmid_busy", 16'(bus.uart_state), 16'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.uart_rx = 1'b1;
    chk("rmid_data",  16'(bus.data_byte),  16'h00);
    chk("rmid_done",  16'(bus.rx_done),    16'd0);
    chk("rmid_ferr",  16'(bus.frame_err),  16'd0);
    chk("rmid_state", 16'(bus.uart_state), 16'd0);
    repeat (3000) @(negedge clk);
    chk("rmid_ndone", 16'(n_done), 16'd4);
    chk("rmid_nerr",  16'(n_err),  16'd1);
    frame(8'h81, 1'b1, 0, -1, -1);
    repeat (20) @(negedge clk);
    chk("f81_data",  16'(bus.data_byte), 16'h81);
    chk("f81_ndone", 16'(n_done), 16'd5);

    // one-clock inverting glitch at the bit 2 sample point of 0xF0
`ifdef BT_RX_MAJORITY_EN
    frame(8'hF0, 1'b1, 0, -1, 1522);
    repeat (20) @(negedge clk);
    chk("glitch_data", 16'(bus.data_byte), 16'hF0);
`else
    frame(8'hF0, 1'b1, 0, -1, 1519);
    repeat (20) @(negedge clk);
    chk("glitch_data", 16'(bus.data_byte), 16'hF4);
`endif
    chk("glitch_ndone", 16'(n_done), 16'd6);

    chk("pulse_both", 16'(n_both), 16'd0);
    chk("pulse_long", 16'(n_long), 16'd0);
    chk("final_nerr", 16'(n_err),  16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
